// File: rtl/mips_alu_pkg.sv
// Shared types for the MIPS-I execute stage: ALU classes, internal ALU functions,
// HI/LO operation codes, funct-field constants and the divide helpers.
package mips_alu_pkg;

   // Operation class driven by the multi-cycle controller
   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_RTYPE = 4'd2,
      ALU_AND   = 4'd3,
      ALU_OR    = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SLT   = 4'd6,
      ALU_SLTU  = 4'd7,
      ALU_LUI   = 4'd8
   } alu_class_e;

   typedef enum logic [4:0] {
      F_ADD   = 5'd0,
      F_SUB   = 5'd1,
      F_AND   = 5'd2,
      F_OR    = 5'd3,
      F_XOR   = 5'd4,
      F_NOR   = 5'd5,
      F_SLT   = 5'd6,
      F_SLTU  = 5'd7,
      F_LUI   = 5'd8,
      F_SLL   = 5'd9,
      F_SRL   = 5'd10,
      F_SRA   = 5'd11,
      F_SLLV  = 5'd12,
      F_SRLV  = 5'd13,
      F_SRAV  = 5'd14,
      F_PASSA = 5'd15,
      F_MFHI  = 5'd16,
      F_MFLO  = 5'd17
   } alu_func_e;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } muldiv_op_e;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   // Returns {remainder, quotient}; caller guarantees d != 0
   function automatic logic [63:0] div_unsigned(input logic [31:0] n, input logic [31:0] d);
      return {n % d, n / d};
   endfunction

   // Signed divide done on magnitudes, so 0x80000000 / -1 wraps to 0x80000000
   // instead of overflowing; remainder takes the dividend's sign.
   function automatic logic [63:0] div_signed(input logic [31:0] n, input logic [31:0] d);
      logic [31:0] mag_n;
      logic [31:0] mag_d;
      logic [31:0] q_mag;
      logic [31:0] r_mag;
      logic [31:0] q;
      logic [31:0] r;
      mag_n = n[31] ? (32'd0 - n) : n;
      mag_d = d[31] ? (32'd0 - d) : d;
      q_mag = mag_n / mag_d;
      r_mag = mag_n % mag_d;
      q     = (n[31] ^ d[31]) ? (32'd0 - q_mag) : q_mag;
      r     = n[31] ? (32'd0 - r_mag) : r_mag;
      return {r, q};
   endfunction

endpackage

// File: rtl/mips_exec_alu_unit_if.sv
// Operand/result bundle between the controller/datapath and the execute stage.
interface mips_exec_alu_unit_if;
   logic [3:0]  alu_op;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] a;
   logic [31:0] b;
   logic        muldiv_write;
   logic [31:0] result;
   logic        zero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output alu_op, funct, shamt, a, b, muldiv_write,
      input  result, zero, hi, lo
   );

   modport slave (
      input  alu_op, funct, shamt, a, b, muldiv_write,
      output result, zero, hi, lo
   );
endinterface

// File: rtl/mips_exec_muldiv.sv
// HI/LO register pair with single-cycle multiply/divide datapath.
// Divider present only when MIPS_ALU_DIV_EN is defined.
module mips_exec_muldiv
   import mips_alu_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  muldiv_op_e  i_op,
   input  logic        i_write,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] w_hi_nxt;
   logic [31:0] w_lo_nxt;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;

   assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   // Next HI/LO selection; every path not listed holds the current value
   always_comb begin
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      if (i_write) begin
         case (i_op)
            MD_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
            MD_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
            MD_MTHI:  w_hi_nxt = i_a;
            MD_MTLO:  w_lo_nxt = i_a;
`ifdef MIPS_ALU_DIV_EN
            MD_DIV: begin
               if (i_b != 32'd0) begin
                  {w_hi_nxt, w_lo_nxt} = div_signed(i_a, i_b);
               end else begin
                  w_hi_nxt = r_hi;
                  w_lo_nxt = r_lo;
               end
            end
            MD_DIVU: begin
               if (i_b != 32'd0) begin
                  {w_hi_nxt, w_lo_nxt} = div_unsigned(i_a, i_b);
               end else begin
                  w_hi_nxt = r_hi;
                  w_lo_nxt = r_lo;
               end
            end
`else
            MD_DIV, MD_DIVU: begin
               w_hi_nxt = r_hi;
               w_lo_nxt = r_lo;
            end
`endif
            default: begin
               w_hi_nxt = r_hi;
               w_lo_nxt = r_lo;
            end
         endcase
      end else begin
         w_hi_nxt = r_hi;
         w_lo_nxt = r_lo;
      end
   end

   // HI/LO state; reset has priority over a pending write
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else begin
         r_hi <= w_hi_nxt;
         r_lo <= w_lo_nxt;
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/mips_exec_alu_unit.sv
// MIPS-I execute stage: alu_op/funct decode, 32-bit ALU and the HI/LO unit.
// Optional divider enabled by defining MIPS_ALU_DIV_EN.
module mips_exec_alu_unit
   import mips_alu_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   mips_exec_alu_unit_if.slave   bus
);

   alu_class_e  w_class;
   alu_func_e   w_func;
   muldiv_op_e  w_mdop;
   logic [31:0] w_result;
   logic [31:0] w_hi;
   logic [31:0] w_lo;

   assign w_class = alu_class_e'(bus.alu_op);

   // Decode class and funct into an ALU function and a HI/LO operation
   always_comb begin
      w_func = F_ADD;
      w_mdop = MD_NONE;
      case (w_class)
         ALU_ADD:  w_func = F_ADD;
         ALU_SUB:  w_func = F_SUB;
         ALU_AND:  w_func = F_AND;
         ALU_OR:   w_func = F_OR;
         ALU_XOR:  w_func = F_XOR;
         ALU_SLT:  w_func = F_SLT;
         ALU_SLTU: w_func = F_SLTU;
         ALU_LUI:  w_func = F_LUI;
         ALU_RTYPE: begin
            case (bus.funct)
               FN_SLL:           w_func = F_SLL;
               FN_SRL:           w_func = F_SRL;
               FN_SRA:           w_func = F_SRA;
               FN_SLLV:          w_func = F_SLLV;
               FN_SRLV:          w_func = F_SRLV;
               FN_SRAV:          w_func = F_SRAV;
               FN_JR, FN_JALR:   w_func = F_PASSA;
               FN_MFHI:          w_func = F_MFHI;
               FN_MFLO:          w_func = F_MFLO;
               FN_MTHI:          w_mdop = MD_MTHI;
               FN_MTLO:          w_mdop = MD_MTLO;
               FN_MULT:          w_mdop = MD_MULT;
               FN_MULTU:         w_mdop = MD_MULTU;
               FN_DIV:           w_mdop = MD_DIV;
               FN_DIVU:          w_mdop = MD_DIVU;
               FN_ADD, FN_ADDU:  w_func = F_ADD;
               FN_SUB, FN_SUBU:  w_func = F_SUB;
               FN_AND:           w_func = F_AND;
               FN_OR:            w_func = F_OR;
               FN_XOR:           w_func = F_XOR;
               FN_NOR:           w_func = F_NOR;
               FN_SLT:           w_func = F_SLT;
               FN_SLTU:          w_func = F_SLTU;
               default:          w_func = F_ADD;
            endcase
         end
         default:  w_func = F_ADD;
      endcase
   end

   // ALU datapath; HI/LO-only functs fall through to a + b
   always_comb begin
      w_result = 32'd0;
      case (w_func)
         F_ADD:   w_result = bus.a + bus.b;
         F_SUB:   w_result = bus.a - bus.b;
         F_AND:   w_result = bus.a & bus.b;
         F_OR:    w_result = bus.a | bus.b;
         F_XOR:   w_result = bus.a ^ bus.b;
         F_NOR:   w_result = ~(bus.a | bus.b);
         F_SLT:   w_result = ($signed(bus.a) < $signed(bus.b)) ? 32'd1 : 32'd0;
         F_SLTU:  w_result = (bus.a < bus.b) ? 32'd1 : 32'd0;
         F_LUI:   w_result = {bus.b[15:0], 16'd0};
         F_SLL:   w_result = bus.b << bus.shamt;
         F_SRL:   w_result = bus.b >> bus.shamt;
         F_SRA:   w_result = $unsigned($signed(bus.b) >>> bus.shamt);
         F_SLLV:  w_result = bus.b << bus.a[4:0];
         F_SRLV:  w_result = bus.b >> bus.a[4:0];
         F_SRAV:  w_result = $unsigned($signed(bus.b) >>> bus.a[4:0]);
         F_PASSA: w_result = bus.a;
         F_MFHI:  w_result = w_hi;
         F_MFLO:  w_result = w_lo;
         default: w_result = bus.a + bus.b;
      endcase
   end

   mips_exec_muldiv u_muldiv (
      .i_clk   (clk),
      .i_reset (reset),
      .i_op    (w_mdop),
      .i_write (bus.muldiv_write),
      .i_a     (bus.a),
      .i_b     (bus.b),
      .o_hi    (w_hi),
      .o_lo    (w_lo)
   );

   assign bus.result = w_result;
   assign bus.zero   = (w_result == 32'd0);
   assign bus.hi     = w_hi;
   assign bus.lo     = w_lo;

endmodule

// File: tb/tb_mips_exec_alu_unit.sv
// Self-checking bench for mips_exec_alu_unit: vector table, hand sequences for
// HI/LO corner cases, and random stimulus against an arithmetic reference model.
module tb_mips_exec_alu_unit;

`ifdef MIPS_ALU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mips_exec_alu_unit_if bus ();

   mips_exec_alu_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [5:0]  fn;
      logic [4:0]  sh;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
   } vec_t;

   vec_t vecs [16];

   logic [5:0] fn_list [0:25] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                  6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                  6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b, input logic wr);
      bus.alu_op       = op;
      bus.funct        = fn;
      bus.shamt        = sh;
      bus.a            = a;
      bus.b            = b;
      bus.muldiv_write = wr;
   endtask

   // Reference ALU from the instruction-set rules
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [5:0] fn,
                                           input logic [4:0] sh, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
      int sa;
      int sb;
      sa = a;
      sb = b;
      case (op)
         4'd1: return a - b;
         4'd3: return a & b;
         4'd4: return a | b;
         4'd5: return a ^ b;
         4'd6: return (sa < sb) ? 32'd1 : 32'd0;
         4'd7: return (a < b) ? 32'd1 : 32'd0;
         4'd8: return b * 32'd65536;
         4'd2: begin
            case (fn)
               6'h00: return b << sh;
               6'h02: return b >> sh;
               6'h03: return sb >>> sh;
               6'h04: return b << a[4:0];
               6'h06: return b >> a[4:0];
               6'h07: return sb >>> a[4:0];
               6'h08, 6'h09: return a;
               6'h10: return hi;
               6'h12: return lo;
               6'h22, 6'h23: return a - b;
               6'h24: return a & b;
               6'h25: return a | b;
               6'h26: return a ^ b;
               6'h27: return ~(a | b);
               6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
               6'h2B: return (a < b) ? 32'd1 : 32'd0;
               default: return a + b;
            endcase
         end
         default: return a + b;
      endcase
   endfunction

   // Reference HI/LO update using 64-bit integer arithmetic
   task automatic model_write(input logic [3:0] op, input logic [5:0] fn,
                              input logic [31:0] a, input logic [31:0] b);
      longint          p;
      longint unsigned pu;
      longint          q;
      longint          r;
      int              sa;
      int              sb;
      sa = a;
      sb = b;
      if (op != 4'd2) return;
      case (fn)
         6'h11: m_hi = a;
         6'h13: m_lo = a;
         6'h18: begin
            p = longint'(sa) * longint'(sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         6'h19: begin
            pu = longint'(a) * longint'(b);
            m_hi = pu[63:32];
            m_lo = pu[31:0];
         end
         6'h1A: if (DIV_EN && b != 32'd0) begin
            q = longint'(sa) / longint'(sb);
            r = longint'(sa) % longint'(sb);
            m_lo = q[31:0];
            m_hi = r[31:0];
         end
         6'h1B: if (DIV_EN && b != 32'd0) begin
            m_lo = a / b;
            m_hi = a % b;
         end
         default: ;
      endcase
   endtask

   // One write cycle: drive with strobe, step the model, sample HI/LO after the edge
   task automatic write_cycle(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                              input string name);
      drive(4'd2, fn, 5'd0, a, b, 1'b1);
      model_write(4'd2, fn, a, b);
      @(posedge clk);
      #1;
      bus.muldiv_write = 1'b0;
      check({name, " hi"}, bus.hi, m_hi);
      check({name, " lo"}, bus.lo, m_lo);
   endtask

   initial begin
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      logic [3:0]  op;
      logic [5:0]  fn;
      logic [4:0]  sh;
      logic [31:0] a;
      logic [31:0] b;
      logic        wr;
      logic [31:0] exp_r;

      n_pass  = 0;
      n_total = 0;
      m_hi    = 32'd0;
      m_lo    = 32'd0;

      vecs[0]  = '{4'd2, 6'h23, 5'd0,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0};
      vecs[1]  = '{4'd1, 6'h00, 5'd0,  32'h1234,     32'h1234,     32'h0,        1'b1};
      vecs[2]  = '{4'd2, 6'h03, 5'd4,  32'h0,        32'h80000000, 32'hF8000000, 1'b0};
      vecs[3]  = '{4'd2, 6'h06, 5'd0,  32'h24,       32'hF0,       32'h0F,       1'b0};
      vecs[4]  = '{4'd6, 6'h00, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
      vecs[5]  = '{4'd7, 6'h00, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
      vecs[6]  = '{4'd8, 6'h00, 5'd0,  32'h0,        32'h1234,     32'h12340000, 1'b0};
      vecs[7]  = '{4'd2, 6'h27, 5'd0,  32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 1'b0};
      vecs[8]  = '{4'd2, 6'h08, 5'd0,  32'hDEADBEEF, 32'd5,        32'hDEADBEEF, 1'b0};
      vecs[9]  = '{4'd2, 6'h00, 5'd31, 32'h0,        32'd3,        32'h80000000, 1'b0};
      vecs[10] = '{4'd2, 6'h07, 5'd0,  32'h21,       32'h80000000, 32'hC0000000, 1'b0};
      vecs[11] = '{4'd9, 6'h00, 5'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
      vecs[12] = '{4'd2, 6'h3F, 5'd0,  32'd2,        32'd3,        32'd5,        1'b0};
      vecs[13] = '{4'd2, 6'h2A, 5'd0,  32'h80000000, 32'd1,        32'd1,        1'b0};
      vecs[14] = '{4'd2, 6'h2B, 5'd0,  32'h80000000, 32'd1,        32'd0,        1'b1};
      vecs[15] = '{4'd2, 6'h18, 5'd0,  32'd4,        32'd5,        32'd9,        1'b0};

      reset = 1'b1;
      drive(4'd0, 6'h00, 5'd0, 32'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset hi", bus.hi, 32'd0);
      check("reset lo", bus.lo, 32'd0);

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].op, vecs[i].fn, vecs[i].sh, vecs[i].a, vecs[i].b, 1'b0);
         #1;
         check($sformatf("vec%0d result", i), bus.result, vecs[i].res);
         check($sformatf("vec%0d zero", i), {31'd0, bus.zero}, {31'd0, vecs[i].z});
      end

      @(posedge clk);
      #1;
      write_cycle(6'h18, 32'hFFFFFFFE, 32'd3, "mult");
      check("mult hi const", bus.hi, 32'hFFFFFFFF);
      check("mult lo const", bus.lo, 32'hFFFFFFFA);
      write_cycle(6'h19, 32'hFFFFFFFE, 32'd3, "multu");
      check("multu hi const", bus.hi, 32'd2);
      check("multu lo const", bus.lo, 32'hFFFFFFFA);
      drive(4'd2, 6'h10, 5'd0, 32'd0, 32'd0, 1'b0);
      #1;
      check("mfhi", bus.result, 32'd2);

      // The write is pending but not yet clocked: HI must still read old
      drive(4'd2, 6'h11, 5'd0, 32'hDEADBEEF, 32'd0, 1'b1);
      #1;
      check("mthi pre-edge hi", bus.hi, 32'd2);
      model_write(4'd2, 6'h11, 32'hDEADBEEF, 32'd0);
      @(posedge clk);
      #1;
      bus.muldiv_write = 1'b0;
      check("mthi hi", bus.hi, 32'hDEADBEEF);

      old_hi = m_hi;
      old_lo = m_lo;
      write_cycle(6'h1A, 32'hFFFFFFF9, 32'd2, "div");
      check("div lo const", bus.lo, DIV_EN ? 32'hFFFFFFFD : old_lo);
      check("div hi const", bus.hi, DIV_EN ? 32'hFFFFFFFF : old_hi);
      old_hi = m_hi;
      old_lo = m_lo;
      write_cycle(6'h1B, 32'd100, 32'd0, "divu by 0");
      check("divu0 hi const", bus.hi, old_hi);
      check("divu0 lo const", bus.lo, old_lo);
      write_cycle(6'h1A, 32'h80000000, 32'hFFFFFFFF, "div minint");
      write_cycle(6'h1B, 32'd100, 32'd7, "divu");

      // Strobe with a non-RTYPE class must not touch HI/LO
      old_hi = m_hi;
      drive(4'd0, 6'h18, 5'd0, 32'd9, 32'd9, 1'b1);
      @(posedge clk);
      #1;
      bus.muldiv_write = 1'b0;
      check("non-rtype write hi", bus.hi, old_hi);

      drive(4'd2, 6'h18, 5'd0, 32'd7, 32'd9, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.muldiv_write = 1'b0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      check("reset+write hi", bus.hi, 32'd0);
      check("reset+write lo", bus.lo, 32'd0);

      for (int it = 0; it < 400; it++) begin
         op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) op = 4'd2;
         fn = fn_list[$urandom_range(0, 25)];
         if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
         sh = 5'($urandom);
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) b = a;
         wr = 1'($urandom_range(0, 1));
         drive(op, fn, sh, a, b, wr);
         #1;
         exp_r = ref_alu(op, fn, sh, a, b, m_hi, m_lo);
         check($sformatf("rnd%0d result", it), bus.result, exp_r);
         check($sformatf("rnd%0d zero", it), {31'd0, bus.zero}, {31'd0, exp_r == 32'd0});
         if (wr) model_write(op, fn, a, b);
         @(posedge clk);
         #1;
         check($sformatf("rnd%0d hi", it), bus.hi, m_hi);
         check($sformatf("rnd%0d lo", it), bus.lo, m_lo);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mips_exec_alu_unit.md
Name: mips_exec_alu_unit

Overview:
- Execute stage of the multi-cycle MIPS-I CPU: ALU opcode decode, combinational 32-bit ALU and the HI/LO multiply/divide register pair.
- The controller supplies a 4-bit ALU class and the instruction funct field.
- The unit produces the ALU result and a zero flag (branch compare), and updates HI/LO on a clocked write strobe.

Parameters:
- None. Data width is fixed at 32.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- alu_op  in  4  operation class from controller
- funct  in  6  instruction[5:0]
- shamt  in  5  instruction[10:6]
- a  in  32  operand A (rs or PC)
- b  in  32  operand B (rt, immediate, or 4)
- muldiv_write  in  1  HI/LO update strobe
- result  out  32  ALU result (combinational)
- zero  out  1  result == 0
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 RTYPE (decode funct), 3 AND, 4 OR, 5 XOR, 6 SLT, 7 SLTU, 8 LUI (result = b<<16).
  - 9-15 behave as ADD.
- RTYPE funct map:
  - 00 SLL, 02 SRL, 03 SRA, 04 SLLV, 06 SRLV, 07 SRAV.
  - 08/09 (JR/JALR) PASS_A (result = a).
  - 10 MFHI (result = hi), 12 MFLO (result = lo).
  - 11 MTHI, 13 MTLO.
  - 18 MULT, 19 MULTU, 1A DIV, 1B DIVU.
  - 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU.
  - Any other funct: ADD.
- Arithmetic is mod 2^32. No overflow traps; ADD and ADDU behave identically.
- Fixed shifts: result = b shifted by shamt.
- Variable shifts: result = b shifted by a[4:0].
- SRA/SRAV are sign-filling.
- SLT is a signed compare, SLTU unsigned; the result is 32'd1 or 32'd0.
- For funct values that are not ALU ops (MTHI/MTLO/MULT/MULTU/DIV/DIVU), result = a + b (don't-care, but fixed).
- zero = (result == 32'd0), purely combinational.
- Mult/div op is derived from the funct map; it is NONE unless alu_op == RTYPE.
- HI/LO update:
  - At posedge clk, if reset: hi = lo = 0.
  - Else if muldiv_write and the op is not NONE:
    - MULT: {hi,lo} = signed a*b (64-bit).
    - MULTU: {hi,lo} = unsigned a*b (64-bit).
    - DIV: lo = signed quotient (truncated toward zero), hi = remainder with the sign of the dividend.
    - DIVU: lo = a/b, hi = a%b, unsigned.
    - MTHI: hi = a. MTLO: lo = a.
  - muldiv_write with op NONE: no change.
- Timing:
  - Divide/multiply complete in the write cycle, with a single-cycle combinational datapath.
  - New hi/lo are visible the cycle after the write edge.
  - MFHI/MFLO issued in the same cycle as a write return the old value.
- Boundary cases:
  - DIV/DIVU with b == 0: hi and lo are unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - Reset asserted together with muldiv_write: reset wins.

Optional Feature:
- MIPS_ALU_DIV_EN
  - Defined: DIV/DIVU are implemented as above.
  - Undefined: no divider hardware; DIV/DIVU with muldiv_write leave hi/lo unchanged. All other ops are unaffected.

Decomposition:
- Package mips_alu_pkg holds:
  - enum alu_class_e (4-bit alu_op codes).
  - enum alu_func_e (5-bit internal ALU function).
  - enum muldiv_op_e (3-bit: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO).
  - funct localparams.
- One sub-module, mips_exec_muldiv, holds the HI/LO registers and the mult/div datapath. Decode and ALU remain in the top block.

Test Plan:
- RTYPE funct 23, a=5, b=7 -> result=0xFFFFFFFE, zero=0. alu_op=1, a=b=0x1234 -> result=0, zero=1.
- RTYPE funct 03, b=0x80000000, shamt=4 -> 0xF8000000. Funct 06, a=0x24, b=0xF0 -> 0x0F (shift by 4).
- alu_op=6, a=0xFFFFFFFF, b=1 -> 1. alu_op=7, same operands -> 0. alu_op=8, b=0x1234 -> 0x12340000.
- MULT with strobe, a=0xFFFFFFFE (-2), b=3 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with same operands -> hi=2, lo=0xFFFFFFFA. Then MFHI -> result=2.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with b=0 -> hi/lo unchanged. With the macro undefined, DIV -> unchanged.
- MTHI a=0xDEADBEEF -> hi=0xDEADBEEF. Reset asserted with the strobe -> hi=lo=0.
